// File: rtl/tt_uio_arb_pkg.sv
// Shared types and constants for the TinyTapeout uio pad arbiter.
package tt_uio_arb_pkg;

  // Width of the uio pad group, fixed by the TinyTapeout pad frame.
  localparam int UIO_W = 8;

  // Width of a requester index (two requesters).
  localparam int IDX_W = 1;

  // Pad output-enable patterns: the whole group drives or the whole group floats.
  localparam logic [UIO_W-1:0] OE_DRIVE = 8'hFF;
  localparam logic [UIO_W-1:0] OE_HIZ   = 8'h00;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2
  } state_t;

  // Converts a requester index into its one-hot grant/valid pattern.
  function automatic logic [1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return idx[0] ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tt_uio_arbiter_rr_arb2.sv
// Two-way grant selection for the uio arbiter.
// Default build: round-robin, the pointer moves past the winner on accept.
// With TT_UIO_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 wins ties
// and no pointer register exists.
module rr_arb2
  import tt_uio_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_req,
  input  logic             i_accept,
  output logic [1:0]       o_gnt,
  output logic [IDX_W-1:0] o_idx
);

`ifdef TT_UIO_ARB_FIXED_PRIO_EN

  // Fixed priority: requester 0 always wins when both ask.
  always_comb begin
    o_gnt = 2'b00;
    if (i_req[0]) begin
      o_gnt = 2'b01;
    end else if (i_req[1]) begin
      o_gnt = 2'b10;
    end
  end

`else

  // r_prio = 0 favours requester 0 on a tie, 1 favours requester 1.
  logic r_prio;

  // Pick the single requester, or the favoured one when both ask.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_prio ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

  // Once a decision is accepted, favour the requester that did not win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (i_accept && (o_gnt != 2'b00)) begin
      r_prio <= o_gnt[0];
    end
  end

`endif

  assign o_idx = o_gnt[1];

endmodule

// File: rtl/tt_uio_arbiter.sv
// Shares the 8-bit bidirectional uio pad group between two requesters.
// Single-word writes drive uio_out with uio_oe=FF, single-word reads sample
// uio_in with uio_oe=00. Pad drive is registered, and a Hi-Z turnaround of
// TURN_CYC cycles is inserted when the bus goes from driving to sampling.
// Build option: TT_UIO_ARB_FIXED_PRIO_EN selects fixed priority in rr_arb2.
module tt_uio_arbiter
  import tt_uio_arb_pkg::*;
#(
  parameter int TURN_CYC = 1,
  parameter int DATA_W   = UIO_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rvalid,
  output logic              busy,
  input  logic [DATA_W-1:0] uio_in,
  output logic [DATA_W-1:0] uio_out,
  output logic [DATA_W-1:0] uio_oe
);

  // Turnaround counter load value; it counts down to zero inside TURN.
  localparam logic [1:0] TURN_LOAD = 2'(TURN_CYC - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [IDX_W-1:0]  r_idx;
  logic              r_we;
  logic [1:0]        r_turn_cnt;
  logic              r_last_wr;
  logic [DATA_W-1:0] r_uio_out;
  logic [DATA_W-1:0] r_uio_oe;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rvalid;

  logic              w_accept;
  logic [1:0]        w_arb_gnt;
  logic [IDX_W-1:0]  w_arb_idx;
  logic              w_win_we;
  logic [DATA_W-1:0] w_win_wdata;

  // A decision is taken only from IDLE while the design is selected.
  assign w_accept    = (r_state == IDLE) && ena && (req != 2'b00);
  assign w_win_we    = we[w_arb_idx];
  assign w_win_wdata = w_arb_idx[0] ? wdata1 : wdata0;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (req),
    .i_accept (w_accept),
    .o_gnt    (w_arb_gnt),
    .o_idx    (w_arb_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a read following a driven bus detours through TURN.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = (!w_win_we && r_last_wr) ? TURN : XFER;
        end
      end
      TURN: begin
        if (r_turn_cnt == 2'd0) begin
          w_state_next = XFER;
        end
      end
      XFER:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Latch the winner at the decision edge and count down the turnaround.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_turn_cnt <= 2'd0;
    end else if (w_accept) begin
      r_idx      <= w_arb_idx;
      r_we       <= w_win_we;
      r_turn_cnt <= TURN_LOAD;
    end else if ((r_state == TURN) && (r_turn_cnt != 2'd0)) begin
      r_turn_cnt <= r_turn_cnt - 2'd1;
    end
  end

  // Pad registers: a write loads the byte and drives; a read floats the bus;
  // the bus stays parked after a write until a read or until ena drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uio_out <= '0;
      r_uio_oe  <= OE_HIZ;
    end else if (w_accept) begin
      if (w_win_we) begin
        r_uio_out <= w_win_wdata;
        r_uio_oe  <= OE_DRIVE;
      end else begin
        r_uio_oe  <= OE_HIZ;
      end
    end else if ((r_state == IDLE) && !ena) begin
      r_uio_oe <= OE_HIZ;
    end
  end

  // Remembers whether the bus was last left driven by a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_wr <= 1'b0;
    end else if (r_state == XFER) begin
      r_last_wr <= r_we;
    end else if ((r_state == IDLE) && !ena) begin
      r_last_wr <= 1'b0;
    end
  end

  // Read capture: uio_in is sampled at the end of a read XFER and flagged
  // valid for one cycle; rdata holds until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 2'b00;
    end else begin
      r_rvalid <= 2'b00;
      if ((r_state == XFER) && !r_we) begin
        r_rdata  <= uio_in;
        r_rvalid <= idx2onehot(r_idx);
      end
    end
  end

  assign gnt     = (r_state == XFER) ? idx2onehot(r_idx) : 2'b00;
  assign busy    = (r_state != IDLE);
  assign rdata   = r_rdata;
  assign rvalid  = r_rvalid;
  assign uio_out = r_uio_out;
  assign uio_oe  = r_uio_oe;

endmodule

// File: tb/tb_tt_uio_arbiter.sv
// Directed scoreboard bench for tt_uio_arbiter (TURN_CYC=1 and TURN_CYC=3).
module tb_tt_uio_arbiter;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] out;
    logic [7:0] oe;
  } gexp_t;

  typedef struct packed {
    logic [1:0] v;
    logic [7:0] d;
  } rexp_t;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [1:0] req, we;
  logic [7:0] wdata0, wdata1, uio_in;
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata, uio_out, uio_oe;
  logic       busy;

  logic [1:0] req_3, we_3;
  logic [7:0] wdata0_3, wdata1_3, uio_in_3;
  logic [1:0] gnt_3, rvalid_3;
  logic [7:0] rdata_3, uio_out_3, uio_oe_3;
  logic       busy_3;

  gexp_t exp_g[$];
  rexp_t exp_r[$];
  int total = 0;
  int bad   = 0;

  tt_uio_arbiter #(.TURN_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .we(we),
    .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .rdata(rdata),
    .rvalid(rvalid), .busy(busy), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe)
  );

  tt_uio_arbiter #(.TURN_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req_3), .we(we_3),
    .wdata0(wdata0_3), .wdata1(wdata1_3), .gnt(gnt_3), .rdata(rdata_3),
    .rvalid(rvalid_3), .busy(busy_3), .uio_in(uio_in_3), .uio_out(uio_out_3),
    .uio_oe(uio_oe_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock; outputs of the main DUT are matched against the scoreboard.
  task automatic tick();
    gexp_t ge;
    rexp_t re;
    @(posedge clk);
    #1;
    if (gnt !== 2'b00) begin
      if (exp_g.size() == 0) begin
        chk("unexpected_gnt", {30'd0, gnt}, 32'd0);
      end else begin
        ge = exp_g.pop_front();
        chk("sb_gnt", {30'd0, gnt}, {30'd0, ge.g});
        chk("sb_uio_out", {24'd0, uio_out}, {24'd0, ge.out});
        chk("sb_uio_oe", {24'd0, uio_oe}, {24'd0, ge.oe});
      end
    end
    if (rvalid !== 2'b00) begin
      if (exp_r.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, rvalid}, 32'd0);
      end else begin
        re = exp_r.pop_front();
        chk("sb_rvalid", {30'd0, rvalid}, {30'd0, re.v});
        chk("sb_rdata", {24'd0, rdata}, {24'd0, re.d});
      end
    end
  endtask

  initial begin
    logic [1:0] e3;
    int hz;
    rst_n = 1'b0; ena = 1'b0; req = 2'b00; we = 2'b00;
    wdata0 = 8'h00; wdata1 = 8'h00; uio_in = 8'h00;
    req_3 = 2'b00; we_3 = 2'b00; wdata0_3 = 8'h00; wdata1_3 = 8'h00; uio_in_3 = 8'h00;

    // Reset values
    tick(); tick();
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_uio_out", {24'd0, uio_out}, 32'd0);
    chk("rst_uio_oe", {24'd0, uio_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1; ena = 1'b1;

    // 1: single write from requester 0
    req = 2'b01; we = 2'b01; wdata0 = 8'hA5;
    exp_g.push_back('{g: 2'b01, out: 8'hA5, oe: 8'hFF});
    tick();
    chk("t1_gnt", {30'd0, gnt}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    req = 2'b00;
    tick();
    chk("t1_busy_low", {31'd0, busy}, 32'd0);
    chk("t1_parked_oe", {24'd0, uio_oe}, 32'hFF);
    chk("t1_parked_out", {24'd0, uio_out}, 32'hA5);

    // 2: read from requester 1 after a write needs one Hi-Z cycle
    req = 2'b10; we = 2'b00; uio_in = 8'h3C;
    exp_g.push_back('{g: 2'b10, out: 8'hA5, oe: 8'h00});
    exp_r.push_back('{v: 2'b10, d: 8'h3C});
    tick();
    chk("t2_turn_oe", {24'd0, uio_oe}, 32'h00);
    chk("t2_turn_gnt", {30'd0, gnt}, 32'd0);
    chk("t2_turn_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t2_gnt", {30'd0, gnt}, 32'd2);
    req = 2'b00;
    tick();
    chk("t2_rvalid", {30'd0, rvalid}, 32'd2);
    chk("t2_rdata", {24'd0, rdata}, 32'h3C);
    uio_in = 8'hFF;
    tick();
    chk("t2_rvalid_pulse", {30'd0, rvalid}, 32'd0);
    chk("t2_rdata_hold", {24'd0, rdata}, 32'h3C);

    // 3: both requesters hold writes; read->write needs no turnaround
    req = 2'b11; we = 2'b11; wdata0 = 8'h11; wdata1 = 8'h22;
    for (int k = 0; k < 4; k++) begin
`ifdef TT_UIO_ARB_FIXED_PRIO_EN
      exp_g.push_back('{g: 2'b01, out: 8'h11, oe: 8'hFF});
`else
      if (k % 2 == 0) exp_g.push_back('{g: 2'b01, out: 8'h11, oe: 8'hFF});
      else            exp_g.push_back('{g: 2'b10, out: 8'h22, oe: 8'hFF});
`endif
    end
    for (int i = 0; i < 8; i++) begin
      tick();
`ifdef TT_UIO_ARB_FIXED_PRIO_EN
      e3 = 2'b01;
`else
      e3 = (i % 4 == 0) ? 2'b01 : 2'b10;
`endif
      if (i % 2 == 0) chk("t3_gnt_on", {30'd0, gnt}, {30'd0, e3});
      else            chk("t3_gnt_off", {30'd0, gnt}, 32'd0);
      if (i == 6) req = 2'b00;
    end

    // 4: ena low blocks grants and releases the parked bus
    chk("t4_oe_parked", {24'd0, uio_oe}, 32'hFF);
    ena = 1'b0; req = 2'b11;
    tick();
    chk("t4_oe_released", {24'd0, uio_oe}, 32'h00);
    chk("t4_no_gnt", {30'd0, gnt}, 32'd0);
    tick();
    chk("t4_no_busy", {31'd0, busy}, 32'd0);
    ena = 1'b1;
    exp_g.push_back('{g: 2'b01, out: 8'h11, oe: 8'hFF});
    tick();
    chk("t4_resume", {30'd0, gnt}, 32'd1);
    req = 2'b00;
    tick();

    // 5: reset during a write XFER
    req = 2'b10; we = 2'b10; wdata1 = 8'h22;
    exp_g.push_back('{g: 2'b10, out: 8'h22, oe: 8'hFF});
    tick();
    chk("t5_in_xfer", {30'd0, gnt}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_gnt", {30'd0, gnt}, 32'd0);
    chk("t5_rst_oe", {24'd0, uio_oe}, 32'h00);
    chk("t5_rst_out", {24'd0, uio_out}, 32'h00);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    chk("t5_no_rvalid", {30'd0, rvalid}, 32'd0);
    rst_n = 1'b1;
    exp_g.push_back('{g: 2'b10, out: 8'h22, oe: 8'hFF});
    tick();
    chk("t5_regrant", {30'd0, gnt}, 32'd2);
    req = 2'b00;
    tick();

    // 6: TURN_CYC=3 instance, write then read then write
    req_3 = 2'b01; we_3 = 2'b01; wdata0_3 = 8'h5A;
    tick();
    chk("t6_wr_gnt", {30'd0, gnt_3}, 32'd1);
    chk("t6_wr_out", {24'd0, uio_out_3}, 32'h5A);
    chk("t6_wr_oe", {24'd0, uio_oe_3}, 32'hFF);
    req_3 = 2'b00;
    tick();
    req_3 = 2'b10; we_3 = 2'b00; uio_in_3 = 8'hC3;
    hz = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gnt_3 !== 2'b00) break;
      chk("t6_hiz_oe", {24'd0, uio_oe_3}, 32'h00);
      hz++;
    end
    chk("t6_hiz_cycles", hz, 32'd3);
    chk("t6_rd_gnt", {30'd0, gnt_3}, 32'd2);
    req_3 = 2'b00;
    tick();
    chk("t6_rvalid", {30'd0, rvalid_3}, 32'd2);
    chk("t6_rdata", {24'd0, rdata_3}, 32'hC3);
    req_3 = 2'b01; we_3 = 2'b01; wdata0_3 = 8'h77;
    tick();
    chk("t6_rw_no_turn", {30'd0, gnt_3}, 32'd1);
    chk("t6_rw_oe", {24'd0, uio_oe_3}, 32'hFF);
    chk("t6_rw_out", {24'd0, uio_out_3}, 32'h77);
    req_3 = 2'b00;
    tick();

    chk("sb_gnt_drained", exp_g.size(), 32'd0);
    chk("sb_read_drained", exp_r.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_uio_arbiter.md
Name: tt_uio_arbiter

Overview:
- Shares the 8-bit bidirectional uio pad group of a TinyTapeout user project between two internal requesters.
- Each requester issues single-word transactions:
  - write: drive a byte onto uio_out with uio_oe=8'hFF;
  - read: sample uio_in with uio_oe=8'h00.
- Round-robin arbitration, registered pad drive, and an enforced Hi-Z turnaround when the bus switches from driving to sampling.
- Sits between the project core and the top-level uio_in/uio_out/uio_oe ports.

Parameters:
- TURN_CYC, 1: Hi-Z cycles inserted on write-to-read switch; legal 1..3.
- DATA_W, 8: uio width; fixed at 8 by the pad frame, exposed only for the package constants.

Ports:
- clk  input  1  project clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design-selected; low blocks new grants
- req  input  2  per-requester transaction request; held until gnt
- we  input  2  per-requester direction, 1=write, 0=read; stable while req
- wdata0  input  8  requester 0 write byte; stable while req
- wdata1  input  8  requester 1 write byte; stable while req
- gnt  output  2  one-hot, one-cycle pulse during the XFER cycle
- rdata  output  8  byte sampled from uio_in
- rvalid  output  2  one-hot pulse, cycle after a read XFER
- busy  output  1  high in any state other than IDLE
- uio_in  input  8  pad input path
- uio_out  output  8  pad output path (registered)
- uio_oe  output  8  pad enable (registered), 8'hFF or 8'h00 only

Behaviour:
Reset (async, rst_n low):
- State=IDLE; gnt=0, rvalid=0, rdata=0, uio_out=0, uio_oe=0, busy=0.
- RR pointer favours requester 0 next; last_wr=0.

States:
- IDLE -> ARB decision is combinational in IDLE.
- IDLE -> TURN if the winner is a read and last_wr=1.
- IDLE -> XFER otherwise.
- TURN: uio_oe=0 for TURN_CYC cycles, then -> XFER.
- XFER: one cycle, then -> IDLE.

Arbitration:
- Evaluated only in IDLE with ena=1.
- Single request wins.
- Both requesting: the requester not granted last wins.
- Winner index and we are latched at the decision edge.

Write timing:
- Decision at edge N.
- In cycle N+1 (XFER): uio_out=latched wdata, uio_oe=8'hFF, gnt[i]=1.
- last_wr is set at the end of XFER.

Read timing:
- XFER cycle: uio_oe=8'h00, gnt[i]=1; uio_in is registered into rdata at the end of XFER.
- rvalid[i]=1 in the following cycle.
- rdata holds its value until the next read.

Pad state between transfers:
- After a write XFER, uio_out and uio_oe hold (bus parked driven) until the next read.
- A read clears uio_oe in its TURN cycle.
- last_wr clears at the read XFER.

Back-to-back:
- Minimum 2 cycles per transaction (IDLE + XFER).
- Write->read costs 2+TURN_CYC.
- Read->write and write->write need no turnaround.

ena:
- ena low in IDLE: no grant; uio_oe forced to 0 at the next edge; last_wr cleared.
- ena low during TURN/XFER: the transaction completes, then the IDLE rule applies.

Protocol rules:
- Requester drops req the cycle after gnt, otherwise a new transaction is issued.
- req deasserted before gnt: the latched transaction still executes (no abort).

Reset mid-transaction: everything returns to reset values immediately; no gnt or rvalid is produced for the aborted transfer.

Optional Feature:
- Macro TT_UIO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 always wins ties; the RR pointer is not instantiated.
- Undefined: round-robin as above.
- Ports and timing are identical in both builds.

Decomposition:
- Package tt_uio_arb_pkg:
  - state enum {IDLE, TURN, XFER};
  - OE_DRIVE=8'hFF, OE_HIZ=8'h00;
  - requester index width constant.
- Sub-module rr_arb2: 2-way round-robin grant with pointer update on accept. Under TT_UIO_ARB_FIXED_PRIO_EN it reduces to fixed priority.
- The FSM, pad registers and read capture stay in tt_uio_arbiter.

Test Plan:
1. Reset, then req=2'b01, we=2'b01, wdata0=8'hA5 -> gnt=2'b01 exactly one cycle later; same cycle uio_out=8'hA5, uio_oe=8'hFF; busy high 1 cycle.
2. After test 1, req=2'b10, we=0, uio_in=8'h3C, TURN_CYC=1 -> one cycle with uio_oe=8'h00 and no gnt; then gnt=2'b10; next cycle rvalid=2'b10 and rdata=8'h3C.
3. Both requesters hold writes (wdata0=8'h11, wdata1=8'h22) for 8 cycles -> uio_out alternates 11,22,11,22; gnt alternates 01/10, every other cycle. Under TT_UIO_ARB_FIXED_PRIO_EN -> only 8'h11 is granted while req0 holds.
4. ena=0 with req=2'b11 -> no gnt; uio_oe=8'h00 next edge. Re-assert ena -> grant resumes in 1 cycle.
5. Assert rst_n=0 during the XFER of a write -> uio_oe=0, gnt=0 immediately, no rvalid. After release, a pending req is granted normally.
6. TURN_CYC=3, write then read -> exactly 3 Hi-Z cycles before the read gnt. Read->write shows 0 turnaround cycles.
